vga_display_ctrl: RTL and testbench
===================================

Name: vga_display_ctrl

Overview:
- Downstream consumer of the VGA timing stage (pixel-clock divider, column/row counters, frame-buffer address counter).
- Converts col/row counts into registered 640x480@60 sync/blank outputs.
- Prefetches frame-buffer pixels through a small FIFO using a request/valid memory handshake.
- Pulses addr_enable to advance the upstream address counter once per pixel fetched, and drives RGB332 to the DAC.

Parameters:
FIFO_DEPTH, 4, prefetch FIFO entries (power of 2, >=2)
DATA_W, 8, pixel width (RGB332)

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
enable  in  1  fetch enable; 0 = no new memory requests
flag_pulse  in  1  one-clk pixel strobe from timing stage
counter_col  in  10  column count 0..799
counter_row  in  10  row count 0..524
counter_addr  in  20  current frame-buffer address
flag_addr  in  1  high when counter_addr == 0x4AFFF (last pixel)
mem_rdata  in  DATA_W  read data
mem_rvalid  in  1  read data valid, one clk
mem_read  out  1  read request, held until mem_rvalid
mem_addr  out  20  read address, registered at request
addr_enable  out  1  one-clk pulse advancing upstream address counter
hsync  out  1  active-low horizontal sync
vsync  out  1  active-low vertical sync
blank_n  out  1  high in visible region
rgb  out  DATA_W  pixel out {R[2:0],G[2:0],B[1:0]}
underflow  out  1  sticky: pixel needed while FIFO empty

Behaviour:
- Reset values: mem_read=0, mem_addr=0, addr_enable=0, hsync=1, vsync=1, blank_n=0, rgb=0, underflow=0, FIFO empty, FSM=IDLE.
- Timing decode (counter values present on a flag_pulse cycle are pre-increment):
  - h_active col<640; hsync low for 656<=col<=751.
  - v_active row<480; vsync low for 490<=row<=491.
  - active = h_active & v_active.
- Output register: hsync, vsync, blank_n, rgb update only on clk edges with flag_pulse=1. Latency one pixel strobe from counter value to pin.
- Pixel pop, on flag_pulse & active:
  - FIFO non-empty: rgb <= head; pop.
  - FIFO empty: rgb <= 0; underflow <= 1; no pop.
  - When not active: rgb <= 0.
- underflow clears only on reset.
- Fetch FSM:
  - IDLE: if enable & FIFO has a free slot (counting the outstanding request): mem_read <= 1, mem_addr <= counter_addr -> WAIT.
  - WAIT: mem_read held high. On mem_rvalid: push mem_rdata, mem_read <= 0, latch last = flag_addr -> ADV.
  - ADV: addr_enable = 1 for exactly one clk. -> DONE if last, else IDLE.
  - DONE: no requests. -> IDLE on the clk with flag_pulse & row==524 & col==0 (prefetch of next frame).
- At most one outstanding request. The next request is issued no earlier than the clk after ADV, so counter_addr has advanced.
- enable low mid-WAIT: request completes normally (push + ADV), then stays in IDLE.
- Simultaneous push and pop: both occur; occupancy unchanged. A pop on an empty FIFO coincident with a push follows the underflow rule; the pushed data is kept.
- FIFO never overflows: a request is issued only when occupancy < FIFO_DEPTH.
- Asynchronous reset mid-operation returns everything to reset values; any outstanding read is dropped (mem_rvalid ignored in IDLE).

Test Plan:
1. Reset, then 800x525 strobes with fetch disabled -> hsync low for exactly 96 strobes/line starting col 656; vsync low for 2 lines (rows 490-491); blank_n high for 640x480 strobes; rgb=0 and underflow=1 after first active strobe.
2. enable=1, memory returns addr[7:0] with 2-clk rvalid latency -> mem_read held 2 clks per fetch; addr_enable exactly one pulse per rvalid; first visible pixels rgb=0x00,0x01,0x02...; underflow stays 0.
3. Hold strobes off after enable -> exactly FIFO_DEPTH=4 requests then mem_read stays 0; the first pop allows exactly one new request.
4. Preload counter_addr=0x4AFFF with flag_addr=1 -> after ADV the FSM sits in DONE with no mem_read until the strobe at row 524/col 0, then the request for addr 0 is issued.
5. Deassert enable during WAIT -> rvalid is accepted, one addr_enable pulse, no further mem_read; re-enable resumes.
6. Assert n_rst low during WAIT, then pulse mem_rvalid -> all outputs at reset values, no push, no addr_enable.

Source files
------------

// File: rtl/vga_display_ctrl.sv
// VGA 640x480@60 display back end: registered sync/blank decode from upstream
// col/row counts, plus a request/valid frame-buffer prefetcher feeding a small pixel FIFO.
module vga_display_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              enable,
    input  logic              flag_pulse,
    input  logic [9:0]        counter_col,
    input  logic [9:0]        counter_row,
    input  logic [19:0]       counter_addr,
    input  logic              flag_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              mem_read,
    output logic [19:0]       mem_addr,
    output logic              addr_enable,
    output logic              hsync,
    output logic              vsync,
    output logic              blank_n,
    output logic [DATA_W-1:0] rgb,
    output logic              underflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ADV,
        DONE
    } state_t;

    state_t             state_reg;
    logic               last_reg;
    logic [DATA_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;

    logic               h_active;
    logic               v_active;
    logic               active;
    logic               hsync_next;
    logic               vsync_next;
    logic               fifo_empty;
    logic               has_room;
    logic               push;
    logic               pop;
    logic               frame_restart;
    logic [DATA_W-1:0]  head;

    always_comb begin
        h_active      = (counter_col < 10'd640);
        v_active      = (counter_row < 10'd480);
        active        = h_active && v_active;
        hsync_next    = !((counter_col >= 10'd656) && (counter_col <= 10'd751));
        vsync_next    = !((counter_row >= 10'd490) && (counter_row <= 10'd491));
        fifo_empty    = (count_reg == '0);
        has_room      = (count_reg < CNT_W'(FIFO_DEPTH));
        push          = (state_reg == WAIT) && mem_rvalid;
        pop           = flag_pulse && active && !fifo_empty;
        frame_restart = flag_pulse && (counter_row == 10'd524) && (counter_col == 10'd0);
        head          = fifo_mem[rd_ptr_reg];
    end

    // Storage carries no reset; validity is tracked entirely by count_reg.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Pins move only on pixel strobes, one strobe behind the counter values.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            blank_n   <= 1'b0;
            rgb       <= '0;
            underflow <= 1'b0;
        end else if (flag_pulse) begin
            hsync   <= hsync_next;
            vsync   <= vsync_next;
            blank_n <= active;
            if (active && !fifo_empty) begin
                rgb <= head;
            end else begin
                rgb <= '0;
            end
            if (active && fifo_empty) begin
                underflow <= 1'b1;
            end
        end
    end

    // One request in flight at most; the ADV cycle lets counter_addr step before the next one.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg   <= IDLE;
            mem_read    <= 1'b0;
            mem_addr    <= '0;
            addr_enable <= 1'b0;
            last_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (enable && has_room) begin
                        mem_read  <= 1'b1;
                        mem_addr  <= counter_addr;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        mem_read    <= 1'b0;
                        last_reg    <= flag_addr;
                        addr_enable <= 1'b1;
                        state_reg   <= ADV;
                    end
                end
                ADV: begin
                    addr_enable <= 1'b0;
                    state_reg   <= last_reg ? DONE : IDLE;
                end
                DONE: begin
                    if (frame_restart) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_display_ctrl.sv
// Directed bench for vga_display_ctrl: timing-decode vector table plus
// hand-written prefetch, end-of-frame, enable and reset sequences.
module tb_vga_display_ctrl;

    localparam int          DATA_W = 8;
    localparam logic [19:0] LAST_ADDR = 20'h4AFFF;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic              enable = 1'b0;
    logic              flag_pulse = 1'b0;
    logic [9:0]        counter_col = '0;
    logic [9:0]        counter_row = '0;
    logic [19:0]       counter_addr = '0;
    logic              flag_addr = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_rvalid = 1'b0;
    logic              mem_read;
    logic [19:0]       mem_addr;
    logic              addr_enable;
    logic              hsync;
    logic              vsync;
    logic              blank_n;
    logic [DATA_W-1:0] rgb;
    logic              underflow;

    vga_display_ctrl #(.FIFO_DEPTH(4), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .enable       (enable),
        .flag_pulse   (flag_pulse),
        .counter_col  (counter_col),
        .counter_row  (counter_row),
        .counter_addr (counter_addr),
        .flag_addr    (flag_addr),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid),
        .mem_read     (mem_read),
        .mem_addr     (mem_addr),
        .addr_enable  (addr_enable),
        .hsync        (hsync),
        .vsync        (vsync),
        .blank_n      (blank_n),
        .rgb          (rgb),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          req_cnt = 0;
    int          ae_cnt = 0;
    int          rd_cycles = 0;
    logic        prev_read = 1'b0;
    logic        mem_auto = 1'b1;
    logic        man_rv = 1'b0;
    logic        pend = 1'b0;
    logic [19:0] pend_addr = '0;

    typedef struct packed {
        logic [9:0] col;
        logic [9:0] row;
        logic       hs;
        logic       vs;
        logic       bl;
    } vec_t;

    vec_t vecs [0:14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock; afterwards model the upstream address counter and a 2-clk memory.
    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_read && !prev_read) req_cnt++;
        if (mem_read) rd_cycles++;
        prev_read = mem_read;
        if (addr_enable) begin
            ae_cnt++;
            counter_addr = (counter_addr == LAST_ADDR) ? 20'h0 : counter_addr + 20'h1;
            flag_addr    = (counter_addr == LAST_ADDR);
        end
        if (!mem_auto) begin
            pend       = 1'b0;
            mem_rvalid = man_rv;
        end else if (mem_rvalid) begin
            mem_rvalid = 1'b0;
        end else if (pend) begin
            mem_rvalid = 1'b1;
            mem_rdata  = pend_addr[7:0];
            pend       = 1'b0;
        end else if (mem_read) begin
            pend      = 1'b1;
            pend_addr = mem_addr;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic strobe(input logic [9:0] col, input logic [9:0] row);
        counter_col = col;
        counter_row = row;
        flag_pulse  = 1'b1;
        tick();
        flag_pulse  = 1'b0;
    endtask

    task automatic do_reset();
        n_rst        = 1'b0;
        enable       = 1'b0;
        flag_pulse   = 1'b0;
        mem_rvalid   = 1'b0;
        man_rv       = 1'b0;
        mem_auto     = 1'b1;
        pend         = 1'b0;
        counter_addr = '0;
        flag_addr    = 1'b0;
        counter_col  = '0;
        counter_row  = '0;
        ticks(3);
        n_rst     = 1'b1;
        req_cnt   = 0;
        ae_cnt    = 0;
        rd_cycles = 0;
        prev_read = 1'b0;
        tick();
    endtask

    task automatic wait_read(input string name);
        int k;
        k = 0;
        while (!mem_read && k < 30) begin
            tick();
            k++;
        end
        check(name, {31'd0, mem_read}, 32'd1);
    endtask

    initial begin
        int hs_low;
        int hs_first;
        int bl_cnt;
        int vs_low;
        int vs_first;

        vecs[0]  = '{10'd0,   10'd0,   1'b1, 1'b1, 1'b1};
        vecs[1]  = '{10'd639, 10'd0,   1'b1, 1'b1, 1'b1};
        vecs[2]  = '{10'd640, 10'd0,   1'b1, 1'b1, 1'b0};
        vecs[3]  = '{10'd655, 10'd0,   1'b1, 1'b1, 1'b0};
        vecs[4]  = '{10'd656, 10'd0,   1'b0, 1'b1, 1'b0};
        vecs[5]  = '{10'd751, 10'd0,   1'b0, 1'b1, 1'b0};
        vecs[6]  = '{10'd752, 10'd0,   1'b1, 1'b1, 1'b0};
        vecs[7]  = '{10'd799, 10'd479, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{10'd639, 10'd479, 1'b1, 1'b1, 1'b1};
        vecs[9]  = '{10'd0,   10'd480, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{10'd0,   10'd489, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{10'd0,   10'd490, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{10'd700, 10'd491, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{10'd0,   10'd492, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{10'd100, 10'd524, 1'b1, 1'b1, 1'b0};

        // Reset values
        do_reset();
        check("rst_mem_read", {31'd0, mem_read}, 32'd0);
        check("rst_mem_addr", {12'd0, mem_addr}, 32'd0);
        check("rst_addr_en", {31'd0, addr_enable}, 32'd0);
        check("rst_hsync", {31'd0, hsync}, 32'd1);
        check("rst_vsync", {31'd0, vsync}, 32'd1);
        check("rst_blank_n", {31'd0, blank_n}, 32'd0);
        check("rst_rgb", {24'd0, rgb}, 32'd0);
        check("rst_underflow", {31'd0, underflow}, 32'd0);

        // Timing decode table, fetch disabled
        for (int v = 0; v < 15; v++) begin
            strobe(vecs[v].col, vecs[v].row);
            $display("vec %0d col=%0d row=%0d hsync=%b vsync=%b blank_n=%b rgb=%0h",
                     v, vecs[v].col, vecs[v].row, hsync, vsync, blank_n, rgb);
            check("vec_hsync", {31'd0, hsync}, {31'd0, vecs[v].hs});
            check("vec_vsync", {31'd0, vsync}, {31'd0, vecs[v].vs});
            check("vec_blank_n", {31'd0, blank_n}, {31'd0, vecs[v].bl});
            check("vec_rgb", {24'd0, rgb}, 32'd0);
            check("vec_underflow", {31'd0, underflow}, 32'd1);
        end

        // No strobe: pins hold even though counters point into sync/active areas
        counter_col = 10'd700;
        counter_row = 10'd490;
        tick();
        check("hold_hsync", {31'd0, hsync}, 32'd1);
        check("hold_vsync", {31'd0, vsync}, 32'd1);

        // One full line and one full column of rows
        hs_low = 0; hs_first = -1; bl_cnt = 0;
        for (int c = 0; c < 800; c++) begin
            strobe(10'(c), 10'd0);
            if (!hsync) begin
                hs_low++;
                if (hs_first < 0) hs_first = c;
            end
            if (blank_n) bl_cnt++;
        end
        $display("line scan: hsync_low=%0d first=%0d blank_n_high=%0d", hs_low, hs_first, bl_cnt);
        check("line_hs_low", hs_low, 32'd96);
        check("line_hs_first", hs_first, 32'd656);
        check("line_blank", bl_cnt, 32'd640);
        vs_low = 0; vs_first = -1;
        for (int r = 0; r < 525; r++) begin
            strobe(10'd0, 10'(r));
            if (!vsync) begin
                vs_low++;
                if (vs_first < 0) vs_first = r;
            end
        end
        $display("frame scan: vsync_low=%0d first=%0d", vs_low, vs_first);
        check("frame_vs_low", vs_low, 32'd2);
        check("frame_vs_first", vs_first, 32'd490);
        check("no_fetch_disabled", req_cnt, 32'd0);

        // Prefetch fill with strobes held off, then paced pops
        do_reset();
        enable = 1'b1;
        ticks(40);
        $display("fill: requests=%0d addr_enable=%0d read_cycles=%0d", req_cnt, ae_cnt, rd_cycles);
        check("fill_requests", req_cnt, 32'd4);
        check("fill_addr_en", ae_cnt, 32'd4);
        check("fill_rd_cycles", rd_cycles, 32'd8);
        check("fill_idle_read", {31'd0, mem_read}, 32'd0);
        check("fill_counter", {12'd0, counter_addr}, 32'd4);
        strobe(10'd0, 10'd0);
        check("pop0_rgb", {24'd0, rgb}, 32'd0);
        check("pop0_underflow", {31'd0, underflow}, 32'd0);
        ticks(20);
        check("refill_one", req_cnt, 32'd5);
        for (int p = 1; p <= 5; p++) begin
            strobe(10'(p), 10'd0);
            $display("pop %0d rgb=%0h underflow=%b", p, rgb, underflow);
            check("pop_rgb", {24'd0, rgb}, p);
            check("pop_underflow", {31'd0, underflow}, 32'd0);
            ticks(7);
        end

        // Last pixel: park in DONE until the row 524 / col 0 strobe
        do_reset();
        counter_addr = LAST_ADDR;
        flag_addr    = 1'b1;
        enable       = 1'b1;
        ticks(40);
        check("last_requests", req_cnt, 32'd1);
        check("last_addr", {12'd0, mem_addr}, {12'd0, LAST_ADDR});
        check("last_addr_en", ae_cnt, 32'd1);
        strobe(10'd1, 10'd524);
        ticks(10);
        check("done_hold", req_cnt, 32'd1);
        strobe(10'd0, 10'd524);
        ticks(3);
        $display("frame restart: requests=%0d mem_addr=%0h", req_cnt, mem_addr);
        check("restart_request", req_cnt, 32'd2);
        check("restart_addr", {12'd0, mem_addr}, 32'd0);

        // enable dropped while a read is in flight
        do_reset();
        enable = 1'b1;
        wait_read("wait_first_read");
        enable = 1'b0;
        ticks(20);
        check("dis_addr_en", ae_cnt, 32'd1);
        check("dis_requests", req_cnt, 32'd1);
        check("dis_read_low", {31'd0, mem_read}, 32'd0);
        enable = 1'b1;
        ticks(20);
        check("reen_requests", req_cnt, 32'd4);

        // Asynchronous reset during WAIT, then stray rvalid pulses
        do_reset();
        enable = 1'b1;
        wait_read("wait_read_rst");
        #2;
        n_rst    = 1'b0;
        enable   = 1'b0;
        mem_auto = 1'b0;
        #1;
        check("arst_mem_read", {31'd0, mem_read}, 32'd0);
        check("arst_mem_addr", {12'd0, mem_addr}, 32'd0);
        check("arst_addr_en", {31'd0, addr_enable}, 32'd0);
        check("arst_blank_n", {31'd0, blank_n}, 32'd0);
        check("arst_hsync", {31'd0, hsync}, 32'd1);
        man_rv = 1'b1;
        tick();
        man_rv = 1'b0;
        tick();
        n_rst  = 1'b1;
        ae_cnt = 0;
        tick();
        man_rv = 1'b1;
        tick();
        man_rv = 1'b0;
        ticks(3);
        check("arst_no_adv", ae_cnt, 32'd0);
        check("arst_underflow0", {31'd0, underflow}, 32'd0);
        strobe(10'd5, 10'd5);
        check("arst_no_push_uf", {31'd0, underflow}, 32'd1);
        check("arst_no_push_rgb", {24'd0, rgb}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
